// File: rtl/sync_fifo_pkg.sv
// Shared constants and status encoding for the parametrised synchronous FIFO.
// Default sizing matches the original 8x8 FIFO.
package sync_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH      = 8;
    localparam int DEF_AW         = $clog2(DEF_DEPTH);
    localparam int DEF_CW         = DEF_AW + 1;
    localparam int DEF_AF_LEVEL   = 6;
    localparam int DEF_AE_LEVEL   = 2;

    // Bit 0 = overflow, bit 1 = underflow.
    typedef enum logic [1:0] {
        ST_OK   = 2'b00,
        ST_OVF  = 2'b01,
        ST_UNF  = 2'b10,
        ST_BOTH = 2'b11
    } fifo_status_e;

endpackage

// File: rtl/sync_fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH register array, synchronous write, asynchronous read.
// The array is intentionally not reset.
module sync_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AW         = 3
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy, almost flags and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int AF_LEVEL   = DEF_AF_LEVEL,
    parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    w_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    r_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);

    logic [AW:0]           w_ptr_q, w_ptr_d, r_ptr_q, r_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  af_q, af_d, ae_q, ae_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .AW         (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (w_ptr_q[AW-1:0]),
        .wdata_i (data_in),
        .raddr_i (r_ptr_q[AW-1:0]),
        .rdata_o (mem_rdata)
    );

    // Acceptance is gated by the registered flags; all flags derive from next-state pointers/count.
    always_comb begin
        wr_acc  = w_en && !full_q;
        rd_acc  = r_en && !empty_q;
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        count_d = count_q;
        if (wr_acc) begin
            w_ptr_d = w_ptr_q + PTR_ONE;
        end else begin
            w_ptr_d = w_ptr_q;
        end
        if (rd_acc) begin
            r_ptr_d = r_ptr_q + PTR_ONE;
        end else begin
            r_ptr_d = r_ptr_q;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        full_d  = (w_ptr_d[AW] != r_ptr_d[AW]) && (w_ptr_d[AW-1:0] == r_ptr_d[AW-1:0]);
        empty_d = (w_ptr_d == r_ptr_d);
        af_d    = (count_d >= AF_C);
        ae_d    = (count_d <= AE_C);
        ovf_d   = w_en && full_q;
        unf_d   = r_en && empty_q;
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr_q <= '0;
            r_ptr_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            w_ptr_q <= w_ptr_d;
            r_ptr_q <= r_ptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            af_q    <= af_d;
            ae_q    <= ae_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = mem_rdata;
`else
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    // Output word loads only on an accepted read and otherwise holds.
    always_comb begin
        if (rd_acc) begin
            dout_d = mem_rdata;
        end else begin
            dout_d = dout_q;
        end
    end

    // Registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign data_out = dout_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param (DEPTH=8, DATA_WIDTH=8, AF=6, AE=2) with a queue scoreboard.
module tb_sync_fifo_param;
    import sync_fifo_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;

    int checks = 0;
    int failures = 0;

    logic [7:0]   exp_q [$];
    int           mdl_cnt = 0;
    logic [7:0]   mdl_dout = 8'h00;
    fifo_status_e mdl_st = ST_OK;

    sync_fifo_param #(
        .DATA_WIDTH (8),
        .DEPTH      (8),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .w_en         (w_en),
        .data_in      (data_in),
        .r_en         (r_en),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus and advance the scoreboard model; no comparisons here.
    task automatic cycle(input logic w, input logic r, input logic [7:0] d);
        logic wa, ra;
        w_en    = w;
        r_en    = r;
        data_in = d;
        wa      = w && (mdl_cnt != 8);
        ra      = r && (mdl_cnt != 0);
        mdl_st  = fifo_status_e'({(r && mdl_cnt == 0), (w && mdl_cnt == 8)});
        if (ra) mdl_dout = exp_q.pop_front();
        if (wa) exp_q.push_back(d);
        mdl_cnt = mdl_cnt + int'(wa) - int'(ra);
        @(posedge clk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    task automatic model_reset();
        exp_q.delete();
        mdl_cnt  = 0;
        mdl_dout = 8'h00;
        mdl_st   = ST_OK;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if ({empty, almost_empty, full, almost_full} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=1100", {empty, almost_empty, full, almost_full});
        end
        checks++;
        if (count !== 4'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d exp=0", count);
        end
        checks++;
        if ({underflow, overflow} !== 2'b00) begin
            failures++;
            $display("FAIL reset_status got=%b exp=00", {underflow, overflow});
        end
`ifndef SYNC_FIFO_FWFT_EN
        checks++;
        if (data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_dout got=%h exp=00", data_out);
        end
`endif
    endtask

`ifndef SYNC_FIFO_FWFT_EN
    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, 8'(i));
            checks++;
            if (count !== 4'(mdl_cnt) || count !== 4'(i)) begin
                failures++;
                $display("FAIL fill_count i=%0d got=%0d exp=%0d", i, count, mdl_cnt);
            end
            checks++;
            if ({full, almost_full, almost_empty, empty} !==
                {(mdl_cnt == 8), (mdl_cnt >= 6), (mdl_cnt <= 2), 1'b0}) begin
                failures++;
                $display("FAIL fill_flags i=%0d got=%b", i, {full, almost_full, almost_empty, empty});
            end
        end
        cycle(1'b1, 1'b0, 8'hFF);
        checks++;
        if ({underflow, overflow} !== 2'(mdl_st) || mdl_st != ST_OVF) begin
            failures++;
            $display("FAIL overflow_pulse got=%b exp=%b", {underflow, overflow}, 2'(mdl_st));
        end
        checks++;
        if (count !== 4'd8 || full !== 1'b1) begin
            failures++;
            $display("FAIL overflow_count got=%0d full=%b exp=8 full=1", count, full);
        end
        cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_one_cycle got=%b exp=0", overflow);
        end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 8'h00);
            checks++;
            if (data_out !== mdl_dout || data_out !== 8'(i + 1)) begin
                failures++;
                $display("FAIL drain_data i=%0d got=%h exp=%h", i, data_out, mdl_dout);
            end
            checks++;
            if (count !== 4'(mdl_cnt) || {underflow, overflow} !== 2'b00) begin
                failures++;
                $display("FAIL drain_count i=%0d got=%0d exp=%0d", i, count, mdl_cnt);
            end
        end
        checks++;
        if (empty !== 1'b1 || almost_empty !== 1'b1) begin
            failures++;
            $display("FAIL drain_empty got=%b%b exp=11", empty, almost_empty);
        end
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if ({underflow, overflow} !== 2'(mdl_st) || mdl_st != ST_UNF) begin
            failures++;
            $display("FAIL underflow_pulse got=%b exp=%b", {underflow, overflow}, 2'(mdl_st));
        end
        checks++;
        if (data_out !== 8'h08 || count !== 4'd0) begin
            failures++;
            $display("FAIL underflow_hold got=%h cnt=%0d exp=08 cnt=0", data_out, count);
        end
        cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL underflow_one_cycle got=%b exp=0", underflow);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'hC0 + 8'(i));
        checks++;
        if (count !== 4'd4) begin
            failures++;
            $display("FAIL b2b_prefill got=%0d exp=4", count);
        end
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b1, 8'h10 + 8'(i));
            checks++;
            if (data_out !== mdl_dout) begin
                failures++;
                $display("FAIL b2b_data i=%0d got=%h exp=%h", i, data_out, mdl_dout);
            end
            checks++;
            if (count !== 4'd4 ||
                {full, empty, almost_full, almost_empty, underflow, overflow} !== 6'b000000) begin
                failures++;
                $display("FAIL b2b_flags i=%0d cnt=%0d flags=%b exp cnt=4 flags=000000", i, count,
                         {full, empty, almost_full, almost_empty, underflow, overflow});
            end
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b0, 8'h77);
        checks++;
        if (count !== 4'd5) begin
            failures++;
            $display("FAIL rstmid_prefill got=%0d exp=5", count);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async cnt=%0d empty=%b full=%b exp cnt=0 empty=1 full=0", count, empty, full);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 8'hA5);
        checks++;
        if (count !== 4'd1 || empty !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_first_write cnt=%0d empty=%b exp cnt=1 empty=0", count, empty);
        end
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (data_out !== mdl_dout || data_out !== 8'hA5) begin
            failures++;
            $display("FAIL rstmid_read got=%h exp=a5", data_out);
        end
    endtask
`else
    task automatic test_fwft();
        cycle(1'b1, 1'b0, 8'h3C);
        checks++;
        if (empty !== 1'b0 || data_out !== exp_q[0] || data_out !== 8'h3C) begin
            failures++;
            $display("FAIL fwft_show got=%h empty=%b exp=3c empty=0", data_out, empty);
        end
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (empty !== 1'b1 || count !== 4'd0 || mdl_dout !== 8'h3C) begin
            failures++;
            $display("FAIL fwft_pop empty=%b cnt=%0d exp empty=1 cnt=0", empty, count);
        end
        cycle(1'b1, 1'b0, 8'h5A);
        cycle(1'b1, 1'b0, 8'h6B);
        checks++;
        if (data_out !== exp_q[0]) begin
            failures++;
            $display("FAIL fwft_head got=%h exp=%h", data_out, exp_q[0]);
        end
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if (data_out !== exp_q[0] || count !== 4'(mdl_cnt)) begin
            failures++;
            $display("FAIL fwft_next got=%h exp=%h", data_out, exp_q[0]);
        end
    endtask
`endif

    initial begin
        test_reset();
`ifndef SYNC_FIFO_FWFT_EN
        test_fill();
        test_drain();
        test_back_to_back();
        test_reset_mid();
`else
        test_fwft();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
